// File: rtl/axis_bin_pkg.sv
// Shared definitions for the bin RAM feeder: field widths, word layout, pack helper, FSM states.
package axis_bin_pkg;

  localparam int unsigned NUMBER_W   = 8;
  localparam int unsigned COUNT_W    = 8;
  localparam int unsigned CBIN_W     = 3;
  localparam int unsigned DBIN_W     = 9;
  localparam int unsigned TDATA_W    = 32;

  localparam int unsigned DBIN_LSB   = 0;
  localparam int unsigned CBIN_LSB   = DBIN_LSB + DBIN_W;
  localparam int unsigned COUNT_LSB  = CBIN_LSB + CBIN_W;
  localparam int unsigned NUMBER_LSB = COUNT_LSB + COUNT_W;
  localparam int unsigned PAD_W      = TDATA_W - NUMBER_LSB - NUMBER_W;

  // RAM word layout, MSB first: pad, number, count, count_bin, data_bin
  typedef struct packed {
    logic [PAD_W-1:0]    pad;
    logic [NUMBER_W-1:0] number;
    logic [COUNT_W-1:0]  count;
    logic [CBIN_W-1:0]   count_bin;
    logic [DBIN_W-1:0]   data_bin;
  } bin_word_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic bin_word_t pack_word(
    input logic [NUMBER_W-1:0] number,
    input logic [COUNT_W-1:0]  count,
    input logic [CBIN_W-1:0]   count_bin,
    input logic [DBIN_W-1:0]   data_bin
  );
    bin_word_t w;
    w.pad       = '0;
    w.number    = number;
    w.count     = count;
    w.count_bin = count_bin;
    w.data_bin  = data_bin;
    return w;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with registered storage; head is valid whenever empty is low.
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only safe when a pop frees the slot in the same cycle
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_bin_packer.sv
// Range-checks and packs bin-update requests, buffers them and streams them out over AXI-Stream.
module axis_bin_packer
  import axis_bin_pkg::*;
#(
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter int unsigned        MEM_DEPTH  = 289,
  parameter logic [COUNT_W-1:0] COUNT_MAX  = 8'h20
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [NUMBER_W-1:0] req_number,
  input  logic [COUNT_W-1:0]  req_count,
  input  logic [CBIN_W-1:0]   req_count_bin,
  input  logic [DBIN_W-1:0]   req_data_bin,
  input  logic                flush,
  output logic                flush_done,
  output logic [TDATA_W-1:0]  m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [7:0]          drop_cnt,
  output logic [15:0]         word_cnt
);

  state_t             state;
  state_t             state_nxt;
  logic               ready_en;
  logic               fire;
  logic               legal;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [TDATA_W-1:0] req_word;

  assign legal    = (32'(req_data_bin) < MEM_DEPTH) && (req_count <= COUNT_MAX);
  assign fire     = req_valid & req_ready;
  assign pop      = m_axis_tvalid & m_axis_tready;
  assign req_word = pack_word(req_number, req_count, req_count_bin, req_data_bin);

  axis_sync_fifo #(
    .WIDTH (TDATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .push      (fire & legal),
    .push_data (req_word),
    .pop       (pop),
    .head      (m_axis_tdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_axis_tvalid = ~fifo_empty;

  // ready_en keeps req_ready low through the first cycle after reset is released
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= RUN;
      ready_en <= 1'b0;
      drop_cnt <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (fire && !legal && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (pop) word_cnt <= word_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        req_ready = ready_en & ~fifo_full;
        if (flush) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) state_nxt = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = flush ? HOLD : RUN;
      end
      HOLD: begin
        if (!flush) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_axis_bin_packer.sv
// Bench for axis_bin_packer: queue-based reference model checked every cycle plus literal checks.
module tb_axis_bin_packer;

  localparam int DEPTH = 4;
  localparam int MD_RESET = 0, MD_ACCEPT = 1, MD_DRAIN = 2, MD_DONE = 3, MD_HOLD = 4;

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_number;
  logic [7:0]  req_count;
  logic [2:0]  req_count_bin;
  logic [8:0]  req_data_bin;
  logic        flush;
  logic        flush_done;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [7:0]  drop_cnt;
  logic [15:0] word_cnt;

  axis_bin_packer dut (
    .aclk          (aclk),
    .areset        (areset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_number    (req_number),
    .req_count     (req_count),
    .req_count_bin (req_count_bin),
    .req_data_bin  (req_data_bin),
    .flush         (flush),
    .flush_done    (flush_done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .drop_cnt      (drop_cnt),
    .word_cnt      (word_cnt)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of expected words and the flush mode
  logic [31:0] mq[$];
  int          m_drops = 0;
  int          m_words = 0;
  int          m_mode  = MD_RESET;
  bit          started = 1'b0;

  function automatic bit m_ready();
    return (m_mode == MD_ACCEPT) && (mq.size() < DEPTH);
  endfunction

  always @(posedge aclk) begin
    bit was_empty, fire, legal, pop;
    started = 1'b1;
    if (areset) begin
      mq.delete();
      m_drops = 0;
      m_words = 0;
      m_mode  = MD_RESET;
    end else begin
      was_empty = (mq.size() == 0);
      fire      = req_valid && m_ready();
      legal     = (int'(req_data_bin) < 289) && (req_count <= 8'h20);
      pop       = !was_empty && m_axis_tready;
      if (pop) begin
        void'(mq.pop_front());
        m_words = (m_words + 1) % 65536;
      end
      if (fire && legal) mq.push_back({4'h0, req_number, req_count, req_count_bin, req_data_bin});
      if (fire && !legal && m_drops < 255) m_drops++;
      case (m_mode)
        MD_RESET:  m_mode = flush ? MD_DRAIN : MD_ACCEPT;
        MD_ACCEPT: if (flush) m_mode = MD_DRAIN;
        MD_DRAIN:  if (was_empty) m_mode = MD_DONE;
        MD_DONE:   m_mode = flush ? MD_HOLD : MD_ACCEPT;
        default:   if (!flush) m_mode = MD_ACCEPT;
      endcase
    end
  end

  always @(negedge aclk) begin
    if (started) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, m_ready()});
      chk("tvalid", {31'd0, m_axis_tvalid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) chk("tdata", m_axis_tdata, mq[0]);
      else if (m_mode == MD_RESET) chk("tdata_rst", m_axis_tdata, 32'd0);
      chk("flush_done", {31'd0, flush_done}, {31'd0, m_mode == MD_DONE});
      chk("drop_cnt", {24'd0, drop_cnt}, {24'd0, m_drops[7:0]});
      chk("word_cnt", {16'd0, word_cnt}, {16'd0, m_words[15:0]});
    end
  end

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic set_req(input logic [7:0] n, input logic [7:0] c, input logic [2:0] cb,
                         input logic [8:0] db);
    req_valid     = 1'b1;
    req_number    = n;
    req_count     = c;
    req_count_bin = cb;
    req_data_bin  = db;
  endtask

  int pulses;

  initial begin
    areset = 1'b1; req_valid = 1'b0; flush = 1'b0; m_axis_tready = 1'b0;
    req_number = '0; req_count = '0; req_count_bin = '0; req_data_bin = '0;

    // reset values
    repeat (3) tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    chk("rst_word", {16'd0, word_cnt}, 32'd0);
    areset = 1'b0;
    chk("ready_at_release", {31'd0, req_ready}, 32'd0);
    tick();
    chk("ready_after_release", {31'd0, req_ready}, 32'd1);

    // single legal request
    set_req(8'hA5, 8'h10, 3'd3, 9'h100);
    m_axis_tready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("single_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("single_tdata", m_axis_tdata, 32'h0A510700);
    tick();
    chk("single_tvalid_off", {31'd0, m_axis_tvalid}, 32'd0);
    chk("single_word_cnt", {16'd0, word_cnt}, 32'd1);

    // backpressure: five requests offered, four fit
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(8'(8'h10 + i), 8'(i), 3'(i), 9'(i));
      tick();
    end
    chk("bp_ready_full", {31'd0, req_ready}, 32'd0);
    chk("bp_head", m_axis_tdata, 32'h01000000);
    req_valid = 1'b0;
    repeat (2) tick();
    chk("bp_head_stable", m_axis_tdata, 32'h01000000);
    m_axis_tready = 1'b1;
    repeat (3) tick();
    chk("bp_last_word", m_axis_tdata, 32'h01303603);
    tick();
    chk("bp_drained", {31'd0, m_axis_tvalid}, 32'd0);
    chk("bp_word_cnt", {16'd0, word_cnt}, 32'd5);

    // illegal requests, then the largest legal ones
    set_req(8'h01, 8'h00, 3'd0, 9'd289);
    tick();
    set_req(8'h01, 8'h21, 3'd0, 9'd0);
    tick();
    req_valid = 1'b0;
    chk("illegal_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("illegal_drop", {24'd0, drop_cnt}, 32'd2);
    set_req(8'h77, 8'h20, 3'd7, 9'd288);
    tick();
    req_valid = 1'b0;
    chk("edge_legal_tdata", m_axis_tdata, 32'h07720F20);
    tick();

    // drop counter saturation
    set_req(8'h00, 8'hFF, 3'd0, 9'h1FF);
    repeat (300) tick();
    req_valid = 1'b0;
    chk("drop_saturated", {24'd0, drop_cnt}, 32'hFF);

    // fill, then stream with continuous requests and tready high
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(8'(8'h40 + i), 8'(i), 3'(i), 9'(9'h20 + i));
      tick();
    end
    chk("full_ready", {31'd0, req_ready}, 32'd0);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(8'(8'h50 + i), 8'(i), 3'(i), 9'(9'h40 + i));
      tick();
    end
    req_valid = 1'b0;
    repeat (6) tick();

    // flush with three words queued and tready toggling
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(8'(8'h60 + i), 8'h01, 3'd1, 9'(i));
      tick();
    end
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_ready_low", {31'd0, req_ready}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      m_axis_tready = ~m_axis_tready;
      tick();
      if (flush_done) pulses++;
    end
    chk("flush_pulses", 32'(pulses), 32'd1);
    chk("hold_ready", {31'd0, req_ready}, 32'd0);
    flush = 1'b0;
    tick();
    chk("after_hold_ready", {31'd0, req_ready}, 32'd1);

    // flush with an empty FIFO
    m_axis_tready = 1'b1;
    flush = 1'b1;
    tick();
    chk("empty_flush_c1", {31'd0, flush_done}, 32'd0);
    flush = 1'b0;
    tick();
    chk("empty_flush_c2", {31'd0, flush_done}, 32'd1);
    tick();
    chk("empty_flush_run", {31'd0, req_ready}, 32'd1);

    // fire in the same cycle flush rises
    m_axis_tready = 1'b0;
    set_req(8'h99, 8'h02, 3'd2, 9'h055);
    flush = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("flush_fire_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    m_axis_tready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (flush_done) pulses++;
    end
    chk("flush_fire_pulses", 32'(pulses), 32'd1);
    flush = 1'b0;
    tick();

    // reset while draining
    m_axis_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(8'(8'h70 + i), 8'h03, 3'd3, 9'(i));
      tick();
    end
    req_valid = 1'b0;
    flush = 1'b1;
    repeat (2) tick();
    areset = 1'b1;
    flush = 1'b0;
    repeat (2) tick();
    chk("drain_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    areset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (flush_done) pulses++;
    end
    chk("drain_rst_no_pulse", 32'(pulses), 32'd0);
    chk("drain_rst_ready", {31'd0, req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
